// File: rtl/cyclic_enc_pkg.sv
// cyclic_enc_pkg: shared state encoding, generator constants and counter sizing for cyclic_lfsr_encoder
package cyclic_enc_pkg;
  typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;
  localparam logic [2:0] G_HAMMING_7_4 = 3'b011;
  localparam logic [3:0] G_HAMMING_15_11 = 4'b0011;
  function automatic int cnt_width(input int k, input int r);
    return $clog2((k > r ? k : r) + 1);
  endfunction
endpackage

// File: rtl/lfsr_divider.sv
// lfsr_divider: R-bit remainder register (ports: clk, reset, clr, shift_fb, shift, din -> rem_next)
module lfsr_divider #(
  parameter int R_BITS = 3,
  parameter logic [R_BITS-1:0] GEN_POLY = 3'b011
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic shift_fb,
  input  logic shift,
  input  logic din,
  output logic [R_BITS-1:0] rem_next
);
  logic [R_BITS-1:0] rem;
  logic fb;
  always_comb begin
    fb = din ^ rem[R_BITS-1];
    rem_next = clr ? '0 : shift_fb ? (rem << 1) ^ (fb ? GEN_POLY : '0) : shift ? rem << 1 : rem;
  end
  always_ff @(posedge clk) begin
    if (reset) rem <= '0;
    else rem <= rem_next;
  end
endmodule

// File: rtl/cyclic_lfsr_encoder.sv
// cyclic_lfsr_encoder: systematic cyclic encoder, message in (in_valid/in_ready/in_msg), serial codeword out (out_valid/out_ready/out_bit/out_last), optional cw_valid/cw_data with CYCLIC_ENC_PARALLEL_EN
module cyclic_lfsr_encoder
  import cyclic_enc_pkg::*;
#(
  parameter int K_BITS = 4,
  parameter int R_BITS = 3,
  parameter logic [R_BITS-1:0] GEN_POLY = 3'b011
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic [K_BITS-1:0] in_msg,
  output logic out_valid,
  input  logic out_ready,
  output logic out_bit,
  output logic out_last
`ifdef CYCLIC_ENC_PARALLEL_EN
  ,
  output logic cw_valid,
  output logic [K_BITS+R_BITS-1:0] cw_data
`endif
);
  localparam int N = K_BITS + R_BITS;
  localparam int CW = cnt_width(K_BITS, R_BITS);
  localparam logic [CW-1:0] K_LAST = CW'(K_BITS - 1);
  localparam logic [CW-1:0] R_LAST = CW'(R_BITS - 1);
  generate
    if (GEN_POLY[0] != 1'b1 || K_BITS < 1 || R_BITS < 2) begin : g_bad_cfg
      $error("cyclic_lfsr_encoder: need GEN_POLY[0]=1, K_BITS>=1, R_BITS>=2");
    end
  endgenerate
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [K_BITS-1:0] msg_sr, msg_d;
  logic [R_BITS-1:0] rem_next;
  logic hs, fin, msg_end, accept;
  assign fin = state == PAR && cnt == R_LAST;
  // next message may be taken on the final parity beat, so in_ready follows out_ready there
  assign in_ready = !reset && (state == IDLE || (fin && out_ready));
  always_comb begin
    hs = state != IDLE && out_ready;
    msg_end = state == MSG && cnt == K_LAST;
    accept = in_valid && in_ready;
    state_d = accept ? MSG : (hs && msg_end) ? PAR : (hs && fin) ? IDLE : state;
    cnt_d = (accept || (hs && (msg_end || fin))) ? '0 : hs ? cnt + CW'(1) : cnt;
    msg_d = accept ? in_msg : (hs && state == MSG) ? msg_sr << 1 : msg_sr;
  end
  lfsr_divider #(.R_BITS(R_BITS), .GEN_POLY(GEN_POLY)) u_div (
    .clk(clk),
    .reset(reset),
    .clr(accept),
    .shift_fb(hs && state == MSG),
    .shift(hs && state == PAR),
    .din(out_bit),
    .rem_next(rem_next)
  );
  // outputs are registered from next-state values so they carry no decode logic
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      msg_sr <= '0;
      out_valid <= 1'b0;
      out_bit <= 1'b0;
      out_last <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      msg_sr <= msg_d;
      out_valid <= state_d != IDLE;
      out_bit <= state_d == MSG ? msg_d[K_BITS-1] : state_d == PAR ? rem_next[R_BITS-1] : 1'b0;
      out_last <= state_d == PAR && cnt_d == R_LAST;
    end
  end
`ifdef CYCLIC_ENC_PARALLEL_EN
  logic [N-1:0] acc;
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      cw_valid <= 1'b0;
      cw_data <= '0;
    end else begin
      cw_valid <= hs && fin;
      if (hs) acc <= {acc[N-2:0], out_bit};
      if (hs && fin) cw_data <= {acc[N-2:0], out_bit};
    end
  end
`endif
endmodule

// File: doc/cyclic_lfsr_encoder.md
# cyclic_lfsr_encoder

Parametrised systematic cyclic (CRC-style) block encoder that divides a K-bit message by a generator polynomial in an R-bit LFSR and streams the N = K+R bit codeword serially, MSB first. It is the generalised successor of the fixed (7,4) Hamming encoder. It sits between a message source and a serial channel/modulator, with valid/ready handshakes on both sides. Defaults reproduce the cyclic (7,4) Hamming code with g(x) = x^3+x+1.

## Interface
- K_BITS, 4, message width; must be ≥1
- R_BITS, 3, parity width = degree of g(x); must be ≥2
- GEN_POLY, 3'b011, R_BITS-bit low coefficients of g(x), g_{R-1}..g_0; the leading x^R term is implicit; bit 0 must be 1
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  message available
- in_ready  output  1  encoder accepts message this cycle
- in_msg  input  K_BITS  message, bit K-1 = highest-degree coefficient
- out_valid  output  1  out_bit valid
- out_ready  input  1  sink accepts out_bit this cycle
- out_bit  output  1  current codeword bit
- out_last  output  1  out_bit is codeword bit 0 (final beat)
- cw_valid  output  1  (CYCLIC_ENC_PARALLEL_EN only) one-cycle codeword-complete strobe
- cw_data  output  K_BITS+R_BITS  (CYCLIC_ENC_PARALLEL_EN only) full codeword {msg, parity}

## Operation
- Codeword c(x) = m(x)·x^R + (m(x)·x^R mod g(x)); serial order c_{N-1} first, so first K beats = message MSB first, last R beats = remainder MSB first.
- States: IDLE, MSG, PAR.
- IDLE: in_ready=1, out_valid=0. On in_valid&in_ready: load msg shift register, clear LFSR to 0, clear beat counter, go MSG.
- MSG: out_valid=1, out_bit = msg_sr[K-1]. On each out handshake: fb = out_bit ^ lfsr[R-1]; lfsr ← {lfsr[R-2:0],0} ^ (fb ? GEN_POLY : 0); msg_sr shifts left; counter++. After the K-th handshake go PAR, counter reset.
- PAR: out_bit = lfsr[R-1]; on handshake lfsr ← {lfsr[R-2:0],0}; counter++. out_last=1 on beat R-1.
- Final PAR handshake: if in_valid, accept next message in same cycle (in_ready = out_ready during final PAR beat; combinational out_ready→in_ready path is intentional) and go MSG; else go IDLE.
- in_ready=0 in MSG and non-final PAR beats.
- Stall: with out_valid=1 and out_ready=0, out_bit, out_last, all state hold.
- Counter width $clog2(max(K,R)+1); no wrap beyond K or R.
- reset: state IDLE, LFSR 0, counter 0, msg_sr 0; any in-flight codeword is discarded, no partial out_last.

## Timing
- Reset values: in_ready=0 while reset high, 1 the cycle after release; out_valid=0, out_bit=0, out_last=0, cw_valid=0, cw_data=0.
- Message accepted at edge t → first bit valid in cycle t+1.
- out_ready held high: beats in cycles t+1..t+N, out_last in t+N; back-to-back message accepted at end of t+N, first bit at t+N+1. Sustained throughput: one codeword per N cycles, no bubbles.
- All outputs except in_ready are registered.

## Configuration
- CYCLIC_ENC_PARALLEL_EN defined: cw_valid and cw_data ports exist; codeword assembled in an N-bit register; cw_valid pulses for one cycle the cycle after the final PAR handshake; cw_data updated at that edge and held until next completion.
- Undefined: ports and register absent; serial stream only; serial behaviour identical.

## Structure
- Package cyclic_enc_pkg: state enum (IDLE, MSG, PAR); constants G_HAMMING_7_4 = 3'b011, G_HAMMING_15_11 = 4'b0011; helper function for counter width.
- Sub-module lfsr_divider: R-bit remainder register with clear, shift-with-feedback (MSG) and shift-only (PAR) controls, parametrised by R_BITS and GEN_POLY. The FSM, counter and msg shift register stay in the top.
- Elaboration check: GEN_POLY[0]==1, K_BITS≥1, R_BITS≥2.

## Test plan
- Reset held 3 cycles then released → all outputs 0 during reset; in_ready=1 first cycle after.
- Defaults, in_msg=4'b1000, out_ready=1 → bits 1,0,0,0,1,0,1; out_last on 7th beat; cw_data=7'b1000101, cw_valid pulse if macro defined.
- Defaults, 4'b1011 then 4'b0001 back-to-back → 1011000 then 0001011, in_ready high on final beat, no idle cycle between codewords.
- Defaults, 4'b1111 with out_ready random 50% → 1111111 delivered; out_bit/out_last stable during every stall.
- K=11, R=4, GEN_POLY=4'b0011, in_msg=11'd1 → 00000000001 then 0011; 15 beats.
- Reset asserted during PAR beat 1 → out_valid=0 next cycle, no out_last; fresh 4'b0001 then yields 0001011 exactly.
